// File: rtl/aes_pkg.sv
// Shared AES byte types, field constants and GF(2^8) helper functions.
package aes_pkg;

  typedef logic [7:0] byte_t;

  // Low byte of the AES field polynomial x^8+x^4+x^3+x+1 (0x11B).
  localparam byte_t GF_POLY    = 8'h1B;
  localparam byte_t SBOX_C     = 8'h63;
  localparam byte_t INV_SBOX_C = 8'h05;

  // Rotate a byte left by n bit positions (n in 0..7).
  function automatic byte_t rotl8(input byte_t b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Shift-and-add multiply in GF(2^8), reducing by GF_POLY on each carry-out.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ GF_POLY) : (aa << 1);
    end
    return p;
  endfunction

  // Forward affine transform applied after the field inverse.
  function automatic byte_t affine_fwd(input byte_t b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ SBOX_C;
  endfunction

  // Inverse affine transform applied before the field inverse.
  function automatic byte_t affine_inv(input byte_t b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ INV_SBOX_C;
  endfunction

endpackage

// File: rtl/gf256_inv.sv
// Combinational multiplicative inverse in GF(2^8) computed as x^254.
// Zero maps to zero naturally since every power of zero is zero.
module gf256_inv
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  byte_t sq;
  byte_t acc;

  // x^254 = x^2 * x^4 * ... * x^128: square repeatedly and accumulate each square.
  always_comb begin
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    y = acc;
  end

endmodule

// File: rtl/aes_sbox_core.sv
// AES forward S-box: combinational output plus a 1-cycle registered copy with valid.
// Optional macro AES_SBOX_INV_EN adds a combinational inverse S-box on inv_in/inv_out.
module aes_sbox_core
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       valid_in,
  output logic [7:0] data_q,
  output logic       valid_q
`ifdef AES_SBOX_INV_EN
  ,
  input  logic [7:0] inv_in,
  output logic [7:0] inv_out
`endif
);

  byte_t fwd_inv_p0;
  byte_t sbox_p0;

  gf256_inv u_fwd_inv (
    .a (data_in),
    .y (fwd_inv_p0)
  );

  // Forward S-box value: affine transform of the field inverse.
  always_comb begin
    sbox_p0 = affine_fwd(fwd_inv_p0);
  end

  assign data_out = sbox_p0;

  // ---- stage p0 -> registered output ----
  // Capture the substituted byte when qualified; valid follows valid_in every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) data_q <= sbox_p0;
    end
  end

`ifdef AES_SBOX_INV_EN
  byte_t inv_aff_p0;

  // Undo the affine step first, then invert in the field.
  always_comb begin
    inv_aff_p0 = affine_inv(inv_in);
  end

  gf256_inv u_rev_inv (
    .a (inv_aff_p0),
    .y (inv_out)
  );
`endif

endmodule

// File: tb/tb_aes_sbox_core.sv
// Directed bench for aes_sbox_core: S-box sweep against the FIPS-197 table,
// registered path with valid/hold/reset, and the optional inverse path.
module tb_aes_sbox_core;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid_in;
  logic [7:0] data_q;
  logic       valid_q;
`ifdef AES_SBOX_INV_EN
  logic [7:0] inv_in;
  logic [7:0] inv_out;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_tab [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  aes_sbox_core dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_in (valid_in),
    .data_q   (data_q),
    .valid_q  (valid_q)
`ifdef AES_SBOX_INV_EN
    ,
    .inv_in   (inv_in),
    .inv_out  (inv_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  int sweep_bad;

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
`ifdef AES_SBOX_INV_EN
    inv_in   = 8'h00;
`endif

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    check8("reset_data_q", data_q, 8'h00);
    check1("reset_valid_q", valid_q, 1'b0);

    // Exhaustive combinational sweep (rst still asserted: data_out must not care).
    sweep_bad = 0;
    for (int i = 0; i < 256; i++) begin
      data_in = 8'(i);
      #1;
      checks++;
      assert (data_out === sbox_tab[i]) else begin
        errors++;
        sweep_bad++;
        $error("FAIL sweep x=%h observed %h expected %h", 8'(i), data_out, sbox_tab[i]);
      end
    end
    if (sweep_bad == 0) $display("sweep 256/256 matched");

    // Spot anchors.
    data_in = 8'h00; #1; check8("anchor_00", data_out, 8'h63);
    data_in = 8'h01; #1; check8("anchor_01", data_out, 8'h7C);
    data_in = 8'h10; #1; check8("anchor_10", data_out, 8'hCA);
    data_in = 8'h53; #1; check8("anchor_53", data_out, 8'hED);
    data_in = 8'hFF; #1; check8("anchor_FF", data_out, 8'h16);

    // Release reset and capture 0x53.
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b1;
    data_in  = 8'h53;
    @(posedge clk); #1;
    check8("cap53_data_q", data_q, 8'hED);
    check1("cap53_valid_q", valid_q, 1'b1);

    // valid_in low: data_q holds, valid_q drops, data_out still live.
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 8'h01;
    @(posedge clk); #1;
    check8("hold_data_q", data_q, 8'hED);
    check1("hold_valid_q", valid_q, 1'b0);
    check8("hold_data_out", data_out, 8'h7C);

    // Capture 0xFF.
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = 8'hFF;
    @(posedge clk); #1;
    check8("capFF_data_q", data_q, 8'h16);
    check1("capFF_valid_q", valid_q, 1'b1);

    // Mid-stream reset with valid_in still high.
    @(negedge clk);
    rst     = 1'b1;
    data_in = 8'h10;
    @(posedge clk); #1;
    check8("midrst_data_q", data_q, 8'h00);
    check1("midrst_valid_q", valid_q, 1'b0);
    check8("midrst_data_out", data_out, 8'hCA);

    // Resume after reset.
    @(negedge clk);
    rst     = 1'b0;
    data_in = 8'h00;
    @(posedge clk); #1;
    check8("resume_data_q", data_q, 8'h63);
    check1("resume_valid_q", valid_q, 1'b1);
    @(negedge clk);
    valid_in = 1'b0;

`ifdef AES_SBOX_INV_EN
    inv_in = 8'h63; #1; check8("inv_63", inv_out, 8'h00);
    inv_in = 8'hED; #1; check8("inv_ED", inv_out, 8'h53);
    inv_in = 8'h16; #1; check8("inv_16", inv_out, 8'hFF);
    for (int i = 0; i < 256; i++) begin
      data_in = 8'(i);
      #1;
      inv_in = data_out;
      #1;
      check8("roundtrip", inv_out, 8'(i));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
